// File: rtl/fetch_unit_pkg.sv
// Shared opcodes, reset/bubble word and FSM state type for the fetch stage.
package fetch_unit_pkg;

  localparam logic [4:0]  OP_HALT  = 5'b00000;
  localparam logic [4:0]  OP_NOP   = 5'b00001;
  localparam logic [4:0]  OP_J     = 5'b00100;
  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetchState_t;

  // pc2 is the fetch address + 2; the J offset is relative to it.
  function automatic logic [15:0] jumpTarget(input logic [15:0] pc2,
                                             input logic [15:0] instr);
    return pc2 + {{5{instr[10]}}, instr[10:0]};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise contents hold.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] instrIn,
  input  logic [15:0] pc2In,
  output logic [15:0] instr,
  output logic [15:0] pc2,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_WORD;
      pc2   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instrIn;
      pc2   <= pc2In;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-entry skid buffer and request FSM.
// Optional macro FETCH_JPREDICT_EN: redirect on fetched J without a bubble.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        halted,
  output logic        err
);

  fetchState_t state, stateNext;
  logic [15:0] pc, pcNext;
  logic [15:0] skid, skidNext;
  logic [15:0] drainAddr, drainAddrNext;
  logic        errNext;
  logic        loadIfId;
  logic [15:0] loadInstr, loadPc2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= '0;
      skid      <= NOP_WORD;
      drainAddr <= '0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      skid      <= skidNext;
      drainAddr <= drainAddrNext;
      err       <= errNext;
    end
  end

  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    skidNext      = skid;
    drainAddrNext = drainAddr;
    errNext       = err;
    loadIfId      = 1'b0;
    loadInstr     = imem_data;
    loadPc2       = pc + 16'd2;

    if (flush) begin
      pcNext  = redirect_pc;
      errNext = err | redirect_pc[0];
      // The outstanding request must still complete at its original address.
      if (state == FETCH && !imem_rdy) begin
        stateNext     = DRAIN;
        drainAddrNext = pc;
      end else if (state == DRAIN && !imem_rdy) begin
        stateNext = DRAIN;
      end else begin
        stateNext = FETCH;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_rdy) begin
            pcNext = pc + 16'd2;
            if (stall) begin
              skidNext  = imem_data;
              stateNext = HOLD;
            end else begin
              loadIfId = 1'b1;
              if (imem_data[15:11] == OP_HALT) stateNext = HALTED;
`ifdef FETCH_JPREDICT_EN
              if (imem_data[15:11] == OP_J) pcNext = jumpTarget(pc + 16'd2, imem_data);
`endif
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            // pc already points past the skid word, so it is that word's pc2.
            loadIfId  = 1'b1;
            loadInstr = skid;
            loadPc2   = pc;
            stateNext = (skid[15:11] == OP_HALT) ? HALTED : FETCH;
`ifdef FETCH_JPREDICT_EN
            if (skid[15:11] == OP_J) pcNext = jumpTarget(pc, skid);
`endif
          end
        end
        DRAIN: begin
          if (imem_rdy) stateNext = FETCH;
        end
        HALTED: stateNext = HALTED;
        default: stateNext = FETCH;
      endcase
    end
  end

  assign imem_req  = rst_n && (state == FETCH || state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drainAddr : pc;
  assign halted    = (state == HALTED);

  if_id_reg uIfId (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (loadIfId),
    .flush   (flush),
    .instrIn (loadInstr),
    .pc2In   (loadPc2),
    .instr   (if_id_instr),
    .pc2     (if_id_pc2),
    .valid   (if_id_valid)
  );

endmodule
